// File: rtl/button_pkg.sv
// Shared definitions for the front-panel button event generator:
// channel FSM encoding, Interrupt bit positions and default counts.
package button_pkg;

  // Per-channel debounce FSM encoding
  localparam logic [1:0] ST_ARM      = 2'd0;
  localparam logic [1:0] ST_RELEASED = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  // Bit positions inside the 4-bit Interrupt vector
  localparam int INT_RST_REL = 0;
  localparam int INT_RST_PRS = 1;
  localparam int INT_PWR_REL = 2;
  localparam int INT_PWR_PRS = 3;

  // Defaults sized for a 32.768 kHz clock: ~20 ms debounce, ~4 s long press
  localparam int DEF_DEBOUNCE_CNT   = 655;
  localparam int DEF_LONG_PRESS_CNT = 131072;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, saturating stability counter
// and ARM/RELEASED/PRESSED FSM. level_o is registered; press_o/release_o
// flag the event that the coming clock edge commits, so the parent can
// register them into pulses aligned with the level_o change.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_ni,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    state_q, state_d;
  logic          level_q, level_d;
  logic          press_d, release_d;

  assign sync = sync_q[1];

  // Synchroniser for the asynchronous raw button; idles at "released"
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_ni};
    end
  end

  // Next-state logic: count stable cycles of the level opposite to the
  // accepted one; any disagreeing sample restarts the count
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      ST_ARM: begin
        // Adopt the current level silently so a button held through
        // reset does not produce a press event
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = sync;
          state_d = sync ? ST_RELEASED : ST_PRESSED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASED: begin
        if (sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = 1'b0;
          state_d = ST_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!sync) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          level_d   = 1'b1;
          state_d   = ST_RELEASED;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_d;
  assign release_o = release_d;
  assign state_o   = state_q;

endmodule

// File: rtl/button_event_gen.sv
// Front-panel button event generator: debounces the active-low power and
// reset buttons and drives the 4-bit Interrupt pulse vector.
// Optional feature macro: BUTTON_LONG_PRESS_EN adds the PwrLongPress output
// and suppresses the power-release pulse that ends a long press.
// DbgState = {power channel state, reset channel state}.
module button_event_gen
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT
`ifdef BUTTON_LONG_PRESS_EN
  ,
  parameter int LONG_PRESS_CNT = DEF_LONG_PRESS_CNT
`endif
) (
  input  logic       CLK32768,
  input  logic       ResetN,
  input  logic       PwrButtonN,
  input  logic       RstButtonN,
  output logic [3:0] Interrupt,
  output logic       PwrButtonDb,
  output logic       RstButtonDb,
`ifdef BUTTON_LONG_PRESS_EN
  output logic       PwrLongPress,
`endif
  output logic [3:0] DbgState
);

  logic       pwr_level, pwr_press, pwr_rel;
  logic       rst_level, rst_press, rst_rel;
  logic [1:0] pwr_state, rst_state;
  logic [3:0] int_q, int_d;

  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_pwr (
    .clk_i     (CLK32768),
    .rst_ni    (ResetN),
    .btn_ni    (PwrButtonN),
    .level_o   (pwr_level),
    .press_o   (pwr_press),
    .release_o (pwr_rel),
    .state_o   (pwr_state)
  );

  button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_rst (
    .clk_i     (CLK32768),
    .rst_ni    (ResetN),
    .btn_ni    (RstButtonN),
    .level_o   (rst_level),
    .press_o   (rst_press),
    .release_o (rst_rel),
    .state_o   (rst_state)
  );

`ifdef BUTTON_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CNT);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CNT - 1);

  logic [LW-1:0] lp_cnt_q, lp_cnt_d;
  logic          long_q, long_d;

  // Long-press timer: runs while the power channel is held pressed and
  // drops together with the debounced release
  always_comb begin
    lp_cnt_d = lp_cnt_q;
    long_d   = long_q;
    if (pwr_rel) begin
      lp_cnt_d = '0;
      long_d   = 1'b0;
    end else if (pwr_state == ST_PRESSED) begin
      if (lp_cnt_q == LP_LAST) begin
        long_d = 1'b1;
      end else begin
        lp_cnt_d = lp_cnt_q + 1'b1;
      end
    end else begin
      lp_cnt_d = '0;
      long_d   = 1'b0;
    end
  end

  // Long-press registers
  always_ff @(posedge CLK32768 or negedge ResetN) begin
    if (!ResetN) begin
      lp_cnt_q <= '0;
      long_q   <= 1'b0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
      long_q   <= long_d;
    end
  end

  assign PwrLongPress = long_q;
`endif

  // Map channel events onto Interrupt bit positions
  always_comb begin
    int_d              = '0;
    int_d[INT_RST_REL] = rst_rel;
    int_d[INT_RST_PRS] = rst_press;
    int_d[INT_PWR_PRS] = pwr_press;
`ifdef BUTTON_LONG_PRESS_EN
    // A release ending a forced-off hold must not look like a soft-off
    int_d[INT_PWR_REL] = pwr_rel & ~long_q;
`else
    int_d[INT_PWR_REL] = pwr_rel;
`endif
  end

  // Register the event pulses so they line up with the *Db level change
  always_ff @(posedge CLK32768 or negedge ResetN) begin
    if (!ResetN) begin
      int_q <= '0;
    end else begin
      int_q <= int_d;
    end
  end

  assign Interrupt   = int_q;
  assign PwrButtonDb = pwr_level;
  assign RstButtonDb = rst_level;
  assign DbgState    = {pwr_state, rst_state};

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen with DEBOUNCE_CNT=4, LONG_PRESS_CNT=16.
// A reference model derives debounced levels and events from the raw
// button history; a monitor compares DUT outputs against queued results.
module tb_button_event_gen;

  localparam int D    = 4;
  localparam int LP   = 16;
  localparam int MAXE = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pwr_n;
  logic       rstb_n;
  logic [3:0] interrupt;
  logic       pwr_db;
  logic       rst_db;
  logic       dut_long;
  logic [3:0] dbg_state;

  button_event_gen #(
    .DEBOUNCE_CNT   (D)
`ifdef BUTTON_LONG_PRESS_EN
    ,
    .LONG_PRESS_CNT (LP)
`endif
  ) dut (
    .CLK32768     (clk),
    .ResetN       (rst_n),
    .PwrButtonN   (pwr_n),
    .RstButtonN   (rstb_n),
    .Interrupt    (interrupt),
    .PwrButtonDb  (pwr_db),
    .RstButtonDb  (rst_db),
`ifdef BUTTON_LONG_PRESS_EN
    .PwrLongPress (dut_long),
`endif
    .DbgState     (dbg_state)
  );

`ifndef BUTTON_LONG_PRESS_EN
  assign dut_long = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc;
  bit mon_en = 1'b0;

  // Clock edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];  // {edge, Interrupt}
  logic [34:0] lvl_q[$];  // {edge, PwrButtonDb, RstButtonDb, PwrLongPress}

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Button b (0 = power, 1 = reset) changes its accepted level at edge m
  // when the synchronised samples of the last D edges all disagree with it
  // and at least D edges have passed since its previous change / arming.
  logic rh     [0:1][0:MAXE-1];
  logic sh     [0:1][0:MAXE-1];
  bit   armed  [0:1];
  logic lvl_m  [0:1];
  int   last_e [0:1];
  int   m;
  int   press_edge;
  logic long_prev;

  task automatic model_reset();
    m          = 0;
    press_edge = 0;
    long_prev  = 1'b0;
    for (int b = 0; b < 2; b++) begin
      armed[b]  = 1'b0;
      lvl_m[b]  = 1'b1;
      last_e[b] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] ev;
    logic       s, all_diff, flipped, long_now;
    ev = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      // two flops between the pin and the debouncer, released level in reset
      s = (m >= 3) ? rh[b][m-2] : 1'b1;
      sh[b][m] = s;
      flipped = 1'b0;
      if (!armed[b]) begin
        if (m == D) begin
          armed[b]  = 1'b1;
          lvl_m[b]  = s;
          last_e[b] = m;
          if (b == 0 && !s) press_edge = m;
        end
      end else if (m - last_e[b] >= D) begin
        all_diff = 1'b1;
        for (int k = m - D + 1; k <= m; k++)
          if (sh[b][k] == lvl_m[b]) all_diff = 1'b0;
        if (all_diff) begin
          lvl_m[b]  = ~lvl_m[b];
          last_e[b] = m;
          flipped   = 1'b1;
        end
      end
      if (flipped) begin
        if (b == 0) begin
          if (!lvl_m[0]) begin
            ev[3]      = 1'b1;
            press_edge = m;
          end else begin
`ifdef BUTTON_LONG_PRESS_EN
            ev[2] = ~long_prev;
`else
            ev[2] = 1'b1;
`endif
          end
        end else begin
          if (!lvl_m[1]) ev[1] = 1'b1;
          else           ev[0] = 1'b1;
        end
      end
    end
`ifdef BUTTON_LONG_PRESS_EN
    long_now = armed[0] && !lvl_m[0] && (m - press_edge >= LP);
`else
    long_now = 1'b0;
`endif
    long_prev = long_now;
    if (ev != 4'b0000) exp_q.push_back({32'(m), ev});
    lvl_q.push_back({32'(m), lvl_m[0], lvl_m[1], long_now});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic p, input logic r);
    m++;
    if (m >= MAXE) begin
      $display("FAIL model_overflow cyc=%0d got=%0d want<%0d", cyc, m, MAXE);
      $fatal(1, "model history exhausted");
    end
    pwr_n    = p;
    rstb_n   = r;
    rh[0][m] = p;
    rh[1][m] = r;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic p, input logic r);
    @(negedge clk);
    #1;
    // anything due at or before the current edge should have been seen
    while (exp_q.size() > 0) begin
      if (exp_q[0][35:4] <= 32'(cyc)) begin
        total++;
        bad++;
        $display("FAIL missing_event cyc=%0d got=none want=%b", cyc, exp_q[0][3:0]);
      end
      void'(exp_q.pop_front());
    end
    lvl_q.delete();
    rst_n  = 1'b0;
    pwr_n  = p;
    rstb_n = r;
    #1;
    check("reset_interrupt", {4'b0, interrupt}, 8'h00);
    check("reset_pwr_db", {7'b0, pwr_db}, 8'h01);
    check("reset_rst_db", {7'b0, rst_db}, 8'h01);
    check("reset_long", {7'b0, dut_long}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic run_random(input int n);
    logic tp, tr, bp, br;
    tp = 1'b1;
    tr = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 39) == 0) tp = ~tp;
      if ($urandom_range(0, 39) == 0) tr = ~tr;
      if ($urandom_range(0, 79) == 0) begin
        tp = ~tp;
        tr = tp;
      end
      bp = ($urandom_range(0, 11) == 0);
      br = ($urandom_range(0, 11) == 0);
      step(tp ^ bp, tr ^ br);
    end
  endtask

  // ---------------- monitor ----------------
  logic [35:0] mon_e;
  logic [34:0] mon_l;

  always @(negedge clk) begin
    if (mon_en && rst_n === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0][35:4] == 32'(cyc)) begin
        mon_e = exp_q.pop_front();
        check("event", {4'b0, interrupt}, {4'b0, mon_e[3:0]});
      end else begin
        check("quiet", {4'b0, interrupt}, 8'h00);
      end
      if (lvl_q.size() > 0 && lvl_q[0][34:3] == 32'(cyc)) begin
        mon_l = lvl_q.pop_front();
        check("levels", {5'b0, pwr_db, rst_db, dut_long}, {5'b0, mon_l[2:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  logic pat [0:8];

  initial begin
    rst_n  = 1'b1;
    pwr_n  = 1'b1;
    rstb_n = 1'b1;
    model_reset();
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // power held through reset: adopted silently, release reported
    do_reset(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    // clean power press and release
    repeat (8) step(1'b0, 1'b1);
    repeat (8) step(1'b1, 1'b1);
    // bouncy reset-button press
    for (int i = 0; i < 9; i++) step(1'b1, pat[i]);
    repeat (6) step(1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b1);
    // both buttons together
    repeat (8) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b1);
    // long power hold then release
    repeat (30) step(1'b0, 1'b1);
    repeat (8) step(1'b1, 1'b1);
    // random activity
    run_random(1500);
    // reset in the middle of a hold
    repeat (12) step(1'b0, 1'b0);
    do_reset(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    repeat (8) step(1'b1, 1'b1);
    // idle reset and more random activity
    do_reset(1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b1);
    run_random(1000);
    repeat (12) step(1'b1, 1'b1);

    @(negedge clk);
    #2;
    check("events_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Front-panel button event generator for ODS-MR. It synchronises and debounces the active-low power and reset buttons and emits single-cycle press and release pulses. These pulses form the 4-bit `Interrupt` vector consumed by the interrupt control/status logic at LPC register 0x09. It is the source end of that interface: the interrupt logic latches the pulses, and this block produces them.

## Interface
- `DEBOUNCE_CNT`, 655: consecutive stable cycles needed to accept a new button level (about 20 ms at 32.768 kHz); legal range ≥ 2.
- `LONG_PRESS_CNT`, 131072: debounced press duration that counts as a long press (about 4 s); only used with `LONG_PRESS_EN`.
- `CLK32768`  in  1  block clock.
- `ResetN`  in  1  asynchronous active-low reset.
- `PwrButtonN`  in  1  raw power button, asynchronous, 0 = pressed.
- `RstButtonN`  in  1  raw reset button, asynchronous, 0 = pressed.
- `Interrupt`  out  4  one-cycle event pulses:
  - [0] reset release (ATX)
  - [1] reset press (legacy)
  - [2] power release (ATX)
  - [3] power press (legacy)
- `PwrButtonDb`  out  1  debounced power button level, 1 = released.
- `RstButtonDb`  out  1  debounced reset button level, 1 = released.
- `PwrLongPress`  out  1  level, high while a long power press is in effect; present only with `LONG_PRESS_EN`.

## Operation
- Each button passes through a 2-flop synchroniser, then its own debounce/event channel.
- Per-channel FSM:
  - ARM: the counter runs for DEBOUNCE_CNT cycles after reset. The debounced level is then loaded from the synchroniser output and the FSM goes to RELEASED or PRESSED. No event is emitted, so a button held through reset produces no spurious press.
  - RELEASED: the counter clears whenever sync = 1 and increments while sync = 0. When it reaches DEBOUNCE_CNT-1 the FSM goes to PRESSED and emits the press pulse.
  - PRESSED: the mirror of RELEASED. When the counter reaches DEBOUNCE_CNT-1 with sync = 1, the FSM goes to RELEASED and emits the release pulse.
- Any bounce (one cycle of the opposite level) restarts the counter from 0.
- Counter width is `$clog2(DEBOUNCE_CNT)`. The counter saturates and never wraps.
- The power and reset channels are fully independent. Simultaneous events on both buttons assert both pulses in the same cycle.
- Release and press pulses of the same button can never coincide.

## Timing
- All outputs are registered.
- Reset values:
  - `Interrupt` = 4'b0000
  - `PwrButtonDb` = 1, `RstButtonDb` = 1
  - `PwrLongPress` = 0
  - counters 0, FSMs in ARM
- Latency: a raw edge held stable at cycle t produces `*Db` change and the event pulse at cycle t+2+DEBOUNCE_CNT (2 synchroniser cycles + debounce).
- Each pulse is exactly 1 cycle wide.
- Minimum spacing between two events of the same button is DEBOUNCE_CNT cycles.
- `ResetN` asserted mid-debounce or mid-press clears all state at once. A pending event is discarded, and the block re-enters ARM on deassertion.

## Configuration
- Macro: `BUTTON_LONG_PRESS_EN`.
- Defined:
  - A second counter, `$clog2(LONG_PRESS_CNT)` bits and saturating, runs in the power channel while it is PRESSED.
  - When the counter reaches LONG_PRESS_CNT-1, `PwrLongPress` goes to 1.
  - `PwrLongPress` stays 1 until the debounced release and clears in the same cycle the release is recognised.
  - The release pulse `Interrupt[2]` that ends a long press is suppressed, so an ATX soft-off never fires after a forced-off hold.
  - The press pulse `Interrupt[3]` is unaffected.
- Undefined: no long-press counter, no `PwrLongPress` port, and `Interrupt[2]` fires on every release.

## Structure
- Shared package `button_pkg`:
  - channel state encoding: ARM, RELEASED, PRESSED
  - `Interrupt` bit index constants: `INT_RST_REL`=0, `INT_RST_PRS`=1, `INT_PWR_REL`=2, `INT_PWR_PRS`=3
  - default count constants
- Sub-module `button_debounce`: synchroniser, counter and FSM, with outputs level/press/release. It is instantiated twice.
- The top level adds the long-press logic and the `Interrupt` bit mapping.

## Test plan
All scenarios use DEBOUNCE_CNT=4 and LONG_PRESS_CNT=16.
- Reset release, both buttons idle high → no `Interrupt` pulse ever; `*Db`=1 after ARM.
- `PwrButtonN` held 0 through reset and after → `PwrButtonDb`=0 after ARM with no `Interrupt[3]`; release then yields one `Interrupt[2]` pulse at t+6.
- Clean power press after ARM → `Interrupt[3]` high for exactly 1 cycle at t+6, `PwrButtonDb` falls in the same cycle.
- Bounce pattern 0,1,0,0,1,0,0,0,0 on `RstButtonN` → single `Interrupt[1]` pulse, 6 cycles after the start of the final stable run.
- Both buttons pressed in the same cycle → `Interrupt`=4'b1010 for 1 cycle; release together → 4'b0101.
- With `BUTTON_LONG_PRESS_EN`, power held 20 cycles past debounce → `PwrLongPress`=1; release → `PwrLongPress` clears, no `Interrupt[2]`. `ResetN` pulsed mid-hold → all outputs return to reset values.
